// File: rtl/shift_reg_sipo.sv
// Serial-in, parallel-out shift register with serial pass-through and word framing.
// Latency: sdi reaches pdo on the next edge and sdo after WIDTH edges; pvalid is registered.
// Backpressure: none; one bit is captured every clock and the block never stalls.
//
// Ports:
//   clk     - system clock, all state updates on the rising edge
//   reset   - synchronous, active-high; clears register, count, strobe (and parity)
//   sdi     - serial data in, captured on every non-reset edge
//   sdo     - serial data out, the far end bit of the register
//   pdo     - parallel view of the register, a direct wire
//   pvalid  - one-cycle strobe, pdo holds a complete WIDTH-bit word
//   bit_cnt - bits captured in the current word, 0..WIDTH-1
//   parity  - even parity of the last completed word (only with SHIFT_REG_SIPO_PARITY_EN)
//
// Optional feature macro: SHIFT_REG_SIPO_PARITY_EN adds the registered parity output.

module shift_reg_sipo #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sdi,
    output logic                     sdo,
    output logic [WIDTH-1:0]         pdo,
    output logic                     pvalid,
`ifdef SHIFT_REG_SIPO_PARITY_EN
    output logic                     parity,
`endif
    output logic [$clog2(WIDTH)-1:0] bit_cnt
);

    localparam int CW = $clog2(WIDTH);
    // Count value on which the current word completes.
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_next;
    logic [CW-1:0]    cnt_q;
    logic             word_done;

    // Next register contents; the direction is fixed at elaboration.
    always_comb begin
        sr_next = sr_q;
        if (MSB_FIRST) begin
            sr_next = {sr_q[WIDTH-2:0], sdi};
        end else begin
            sr_next = {sdi, sr_q[WIDTH-1:1]};
        end
    end

    // The edge that captures bit WIDTH-1 of a word is the edge that completes it.
    assign word_done = (cnt_q == LAST_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            pvalid <= 1'b0;
        end else begin
            sr_q   <= sr_next;
            // Explicit wrap so that non-power-of-two widths frame correctly.
            cnt_q  <= word_done ? '0 : cnt_q + CW'(1);
            pvalid <= word_done;
        end
    end

`ifdef SHIFT_REG_SIPO_PARITY_EN
    // sr_next is exactly the word that becomes visible alongside pvalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            parity <= 1'b0;
        end else if (word_done) begin
            parity <= ^sr_next;
        end
    end
`endif

    assign pdo     = sr_q;
    assign sdo     = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
    assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_shift_reg_sipo.sv
module tb_shift_reg_sipo;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: WIDTH=4, MSB first
    logic       rst4 = 1'b1;
    logic       sdi4 = 1'b0;
    logic       sdo4;
    logic [3:0] pdo4;
    logic       vld4;
    logic [1:0] cnt4;
    // DUT B: WIDTH=8, LSB first
    logic       rst8 = 1'b1;
    logic       sdi8 = 1'b0;
    logic       sdo8;
    logic [7:0] pdo8;
    logic       vld8;
    logic [2:0] cnt8;
`ifdef SHIFT_REG_SIPO_PARITY_EN
    logic       par4;
    logic       par8;
`endif

    shift_reg_sipo #(.WIDTH(4), .MSB_FIRST(1'b1)) dut4 (
        .clk(clk), .reset(rst4), .sdi(sdi4), .sdo(sdo4), .pdo(pdo4), .pvalid(vld4),
`ifdef SHIFT_REG_SIPO_PARITY_EN
        .parity(par4),
`endif
        .bit_cnt(cnt4)
    );

    shift_reg_sipo #(.WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
        .clk(clk), .reset(rst8), .sdi(sdi8), .sdo(sdo8), .pdo(pdo8), .pvalid(vld8),
`ifdef SHIFT_REG_SIPO_PARITY_EN
        .parity(par8),
`endif
        .bit_cnt(cnt8)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: history of captured bits, newest first, plus count since reset.
    bit q4[$];
    bit q8[$];
    int n4 = 0;
    int n8 = 0;
    bit m_par4 = 1'b0;
    bit m_par8 = 1'b0;

    // Word as seen on pdo: the bit captured i edges ago sits i places from the input end.
    function automatic logic [63:0] model_pdo(input bit q[$], input int n, input int w, input bit msbf);
        logic [63:0] r;
        bit b;
        r = '0;
        for (int i = 0; i < w; i++) begin
            b = (i < n && i < q.size()) ? q[i] : 1'b0;
            if (msbf) r[i] = b;
            else      r[w-1-i] = b;
        end
        return r;
    endfunction

    // sdo is sdi delayed by w edges: the bit captured w-1 edges before the latest.
    function automatic bit model_sdo(input bit q[$], input int n, input int w);
        return (n >= w) ? q[w-1] : 1'b0;
    endfunction

    // One clock: inputs are held across the edge, then the model absorbs them.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (rst4) begin
            q4.delete(); n4 = 0; m_par4 = 1'b0;
        end else begin
            q4.push_front(sdi4);
            if (q4.size() > 64) void'(q4.pop_back());
            n4++;
            if (n4 % 4 == 0) m_par4 = ^model_pdo(q4, n4, 4, 1'b1);
        end
        if (rst8) begin
            q8.delete(); n8 = 0; m_par8 = 1'b0;
        end else begin
            q8.push_front(sdi8);
            if (q8.size() > 64) void'(q8.pop_back());
            n8++;
            if (n8 % 8 == 0) m_par8 = ^model_pdo(q8, n8, 8, 1'b0);
        end
    endtask

    task automatic check_models();
        chk("rnd4_pdo", 64'(pdo4), model_pdo(q4, n4, 4, 1'b1));
        chk("rnd4_sdo", 64'(sdo4), 64'(model_sdo(q4, n4, 4)));
        chk("rnd4_cnt", 64'(cnt4), 64'(n4 % 4));
        chk("rnd4_vld", 64'(vld4), 64'(n4 > 0 && n4 % 4 == 0));
        chk("rnd8_pdo", 64'(pdo8), model_pdo(q8, n8, 8, 1'b0));
        chk("rnd8_sdo", 64'(sdo8), 64'(model_sdo(q8, n8, 8)));
        chk("rnd8_cnt", 64'(cnt8), 64'(n8 % 8));
        chk("rnd8_vld", 64'(vld8), 64'(n8 > 0 && n8 % 8 == 0));
`ifdef SHIFT_REG_SIPO_PARITY_EN
        chk("rnd4_par", 64'(par4), 64'(m_par4));
        chk("rnd8_par", 64'(par8), 64'(m_par8));
`endif
    endtask

    typedef struct {
        bit         rst;
        bit         sdi;
        logic [3:0] pdo;
        bit         vld;
        logic [1:0] cnt;
        bit         sdo;
    } vec_t;

    vec_t tv[21];

    initial begin
        logic [11:0] stream;
        logic [7:0]  word;

        // Reset, single pulse, framing, reset mid-word (WIDTH=4, MSB first).
        tv[0]  = '{1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
        tv[1]  = '{1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
        tv[2]  = '{1'b0, 1'b1, 4'b0001, 1'b0, 2'd1, 1'b0};
        tv[3]  = '{1'b0, 1'b0, 4'b0010, 1'b0, 2'd2, 1'b0};
        tv[4]  = '{1'b0, 1'b0, 4'b0100, 1'b0, 2'd3, 1'b0};
        tv[5]  = '{1'b0, 1'b0, 4'b1000, 1'b1, 2'd0, 1'b1};
        tv[6]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0};
        tv[7]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        tv[8]  = '{1'b0, 1'b1, 4'b0001, 1'b0, 2'd1, 1'b0};
        tv[9]  = '{1'b0, 1'b0, 4'b0010, 1'b0, 2'd2, 1'b0};
        tv[10] = '{1'b0, 1'b1, 4'b0101, 1'b0, 2'd3, 1'b0};
        tv[11] = '{1'b0, 1'b1, 4'b1011, 1'b1, 2'd0, 1'b1};
        tv[12] = '{1'b0, 1'b0, 4'b0110, 1'b0, 2'd1, 1'b0};
        tv[13] = '{1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        tv[14] = '{1'b0, 1'b1, 4'b0001, 1'b0, 2'd1, 1'b0};
        tv[15] = '{1'b0, 1'b1, 4'b0011, 1'b0, 2'd2, 1'b0};
        tv[16] = '{1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
        tv[17] = '{1'b0, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0};
        tv[18] = '{1'b0, 1'b1, 4'b0001, 1'b0, 2'd2, 1'b0};
        tv[19] = '{1'b0, 1'b0, 4'b0010, 1'b0, 2'd3, 1'b0};
        tv[20] = '{1'b0, 1'b1, 4'b0101, 1'b1, 2'd0, 1'b0};

        for (int i = 0; i < 21; i++) begin
            rst4 = tv[i].rst;
            sdi4 = tv[i].sdi;
            cycle();
            chk($sformatf("tv%0d_pdo", i), 64'(pdo4), 64'(tv[i].pdo));
            chk($sformatf("tv%0d_vld", i), 64'(vld4), 64'(tv[i].vld));
            chk($sformatf("tv%0d_cnt", i), 64'(cnt4), 64'(tv[i].cnt));
            chk($sformatf("tv%0d_sdo", i), 64'(sdo4), 64'(tv[i].sdo));
        end

        // Continuous 12-bit stream: strobes on cycles 4, 8, 12 with the matching group.
        rst4 = 1'b1; sdi4 = 1'b0;
        cycle();
        rst4 = 1'b0;
        stream = 12'b1100_1010_0111;
        for (int k = 1; k <= 12; k++) begin
            sdi4 = stream[12-k];
            cycle();
            chk($sformatf("strm%0d_vld", k), 64'(vld4), 64'(k % 4 == 0));
            if (k % 4 == 0)
                chk($sformatf("strm%0d_pdo", k), 64'(pdo4), 64'((stream >> (12 - k)) & 12'hF));
        end

        // Randomised run of both instances against the reference model.
        rst8 = 1'b1;
        cycle();
        for (int c = 0; c < 400; c++) begin
            rst4 = ($urandom_range(15) == 0);
            rst8 = ($urandom_range(15) == 0);
            sdi4 = 1'($urandom);
            sdi8 = 1'($urandom);
            cycle();
            check_models();
        end

        // WIDTH=8 LSB first: 0xA5 then 0x01, least significant bit first.
        rst4 = 1'b1;
        rst8 = 1'b1;
        cycle();
        rst8 = 1'b0;
        word = 8'hA5;
        for (int b = 0; b < 8; b++) begin
            sdi8 = word[b];
            cycle();
            chk($sformatf("a5_vld%0d", b), 64'(vld8), 64'(b == 7));
        end
        chk("a5_pdo", 64'(pdo8), 64'h A5);
`ifdef SHIFT_REG_SIPO_PARITY_EN
        chk("a5_par", 64'(par8), 64'd0);
`endif
        word = 8'h01;
        for (int b = 0; b < 8; b++) begin
            sdi8 = word[b];
            cycle();
        end
        chk("w01_pdo", 64'(pdo8), 64'h01);
        chk("w01_vld", 64'(vld8), 64'd1);
        chk("w01_sdo", 64'(sdo8), 64'd1);
`ifdef SHIFT_REG_SIPO_PARITY_EN
        chk("w01_par", 64'(par8), 64'd1);
`endif
        sdi8 = 1'b0;
        cycle();
        chk("w01_vld_drop", 64'(vld8), 64'd0);
`ifdef SHIFT_REG_SIPO_PARITY_EN
        chk("w01_par_hold", 64'(par8), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
